// File: rtl/xadc_drp_if.sv
// DRP-side signal bundle between the XADC wizard and the read sequencer.
// The master modport is the sequencer; the slave modport is the XADC side.
interface xadc_drp_if;
    logic        eoc;
    logic        drdy;
    logic [15:0] do_in;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;

    modport master (input eoc, drdy, do_in, output den, dwe, daddr);
    modport slave  (output eoc, drdy, do_in, input den, dwe, daddr);
endinterface

// File: rtl/xadc_multi_pwm.sv
// Round-robin XADC DRP reader with optional EMA smoothing and one PWM LED per channel.
//
// state       | meaning
// S_IDLE      | sequencer stopped, eoc ignored
// S_WAIT_EOC  | armed, next eoc launches a DRP read of channel idx
// S_WAIT_DRDY | read in flight, waiting for drdy or timeout
module xadc_multi_pwm #(
    parameter int                  NUM_CH    = 4,
    parameter logic [7*NUM_CH-1:0] CH_ADDRS  = {7'h16, 7'h1F, 7'h17, 7'h1E},
    parameter int                  PWM_BITS  = 8,
    parameter int                  AVG_SHIFT = 0,
    parameter int                  TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   resetn,
    xadc_drp_if.master             drp,
    input  logic                   en_i,
    input  logic                   clr_err_i,
    output logic [NUM_CH-1:0]      led_o,
    output logic [NUM_CH*12-1:0]   value_o,
    output logic                   sample_valid_o,
    output logic [3:0]             sample_ch_o,
    output logic                   timeout_err_o
);
    localparam int AW = 12 + AVG_SHIFT;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_EOC, S_WAIT_DRDY} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, idx_nxt;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                stop_q, stop_d;
    logic                den_q, den_d;
    logic [6:0]          daddr_q, daddr_d;
    logic                terr_q, terr_d;
    logic                sv_q, sv_d;
    logic [3:0]          sch_q, sch_d;
    logic                capture, tmo;
    logic [11:0]         raw;
    logic                unused_lsbs;
    logic [AW-1:0]       acc_q [NUM_CH];
    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_q [NUM_CH];
    logic [NUM_CH-1:0]   led_q;

    assign raw         = drp.do_in[15:4];
    assign unused_lsbs = ^drp.do_in[3:0];
    assign idx_nxt     = (idx_q == IW'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        stop_d  = stop_q;
        den_d   = 1'b0;
        daddr_d = daddr_q;
        sv_d    = 1'b0;
        sch_d   = sch_q;
        capture = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i) state_d = S_WAIT_EOC;
            end
            S_WAIT_EOC: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (drp.eoc) begin
                    den_d   = 1'b1;
                    daddr_d = CH_ADDRS[7*int'(idx_q) +: 7];
                    tmr_d   = TW'(TIMEOUT - 1);
                    stop_d  = 1'b0;
                    state_d = S_WAIT_DRDY;
                end
            end
            S_WAIT_DRDY: begin
                // drdy takes priority over an expiring timer
                if (drp.drdy)          capture = 1'b1;
                else if (tmr_q == '0)  tmo     = 1'b1;
                else                   tmr_d   = tmr_q - 1'b1;
                if (capture || tmo) begin
                    idx_d   = idx_nxt;
                    state_d = (stop_q || !en_i) ? S_IDLE : S_WAIT_EOC;
                end else begin
                    stop_d = stop_q | ~en_i;
                end
                if (capture) begin
                    sv_d  = 1'b1;
                    sch_d = 4'(idx_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
        terr_d = tmo | (terr_q & ~clr_err_i);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            stop_q  <= 1'b0;
            den_q   <= 1'b0;
            daddr_q <= CH_ADDRS[6:0];
            terr_q  <= 1'b0;
            sv_q    <= 1'b0;
            sch_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            stop_q  <= stop_d;
            den_q   <= den_d;
            daddr_q <= daddr_d;
            terr_q  <= terr_d;
            sv_q    <= sv_d;
            sch_q   <= sch_d;
        end
    end

    // With AVG_SHIFT=0 the update collapses to acc = raw.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else if (capture) begin
            acc_q[idx_q] <= acc_q[idx_q] - (acc_q[idx_q] >> AVG_SHIFT) + AW'(raw);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            led_q <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                led_q[i] <= (cnt_q < duty_q[i]);
                if (cnt_q == CNT_MAX) duty_q[i] <= value_o[12*i+11 -: PWM_BITS];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_value
        assign value_o[12*g +: 12] = 12'(acc_q[g] >> AVG_SHIFT);
    end

    assign drp.den        = den_q;
    assign drp.dwe        = 1'b0;
    assign drp.daddr      = daddr_q;
    assign led_o          = led_q;
    assign sample_valid_o = sv_q;
    assign sample_ch_o    = sch_q;
    assign timeout_err_o  = terr_q;
endmodule

// File: tb/tb_xadc_multi_pwm.sv
// Bench for xadc_multi_pwm: two instances (no filter / AVG_SHIFT=2) on shared stimulus,
// checked every cycle against a transaction-level model plus hand-computed literals.
module tb_xadc_multi_pwm;
    localparam int NUM_CH = 4;
    localparam int TO     = 255;

    logic        clk = 1'b0;
    logic        resetn, en, eoc, drdy, clr_err;
    logic [15:0] do_in;
    bit          chk_on = 1'b0;
    int          checks = 0, errors = 0;
    int          den_cnt = 0, sv_cnt = 0;
    logic [6:0]  addr_log[$];
    logic [3:0]  sch_log[$];

    logic [NUM_CH-1:0]    led0, led1;
    logic [NUM_CH*12-1:0] val0, val1;
    logic                 sv0, sv1, terr0, terr1;
    logic [3:0]           sch0, sch1;

    always #5 clk = ~clk;

    xadc_drp_if drp0();
    xadc_drp_if drp1();
    assign drp0.eoc = eoc;  assign drp0.drdy = drdy;  assign drp0.do_in = do_in;
    assign drp1.eoc = eoc;  assign drp1.drdy = drdy;  assign drp1.do_in = do_in;

    xadc_multi_pwm #(.AVG_SHIFT(0)) u0 (
        .clk(clk), .resetn(resetn), .drp(drp0), .en_i(en), .clr_err_i(clr_err),
        .led_o(led0), .value_o(val0), .sample_valid_o(sv0), .sample_ch_o(sch0),
        .timeout_err_o(terr0));
    xadc_multi_pwm #(.AVG_SHIFT(2)) u1 (
        .clk(clk), .resetn(resetn), .drp(drp1), .en_i(en), .clr_err_i(clr_err),
        .led_o(led1), .value_o(val1), .sample_valid_o(sv1), .sample_ch_o(sch1),
        .timeout_err_o(terr1));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int addr_tab[NUM_CH] = '{'h1E, 'h17, 'h1F, 'h16};
    int shift_tab[2]     = '{0, 2};
    int m_busy, m_armed, m_idx, m_wait, m_cnt;
    bit m_stop;
    int m_acc[2][NUM_CH];
    int m_duty[2][NUM_CH];
    bit m_led[2][NUM_CH];
    bit e_den, e_sv, e_terr;
    int e_daddr, e_sch;

    function automatic int mval(int k, int c);
        return m_acc[k][c] >> shift_tab[k];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_armed = 0; m_idx = 0; m_wait = 0; m_cnt = 0; m_stop = 0;
        e_den = 0; e_sv = 0; e_terr = 0; e_daddr = 'h1E; e_sch = 0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NUM_CH; c++) begin
                m_acc[k][c] = 0; m_duty[k][c] = 0; m_led[k][c] = 0;
            end
    endtask

    task automatic model_step();
        bit tmo_now, done;
        int raw;
        tmo_now = 0; done = 0;
        raw = int'(do_in[15:4]);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NUM_CH; c++) begin
                m_led[k][c] = (m_cnt < m_duty[k][c]);
                if (m_cnt == 255) m_duty[k][c] = mval(k, c) / 16;
            end
        m_cnt = (m_cnt + 1) % 256;
        e_den = 0; e_sv = 0;
        if (m_busy == 1) begin
            m_wait++;
            if (!en) m_stop = 1;
            if (drdy) begin
                for (int k = 0; k < 2; k++)
                    m_acc[k][m_idx] = m_acc[k][m_idx] - (m_acc[k][m_idx] >> shift_tab[k]) + raw;
                e_sv = 1; e_sch = m_idx; done = 1;
            end else if (m_wait == TO) begin
                tmo_now = 1; done = 1;
            end
            if (done) begin
                m_idx  = (m_idx + 1) % NUM_CH;
                m_busy = 0;
                m_armed = m_stop ? 0 : 1;
            end
        end else if (m_armed == 0) begin
            if (en) m_armed = 1;
        end else begin
            if (!en) m_armed = 0;
            else if (eoc) begin
                e_den = 1; e_daddr = addr_tab[m_idx];
                m_busy = 1; m_wait = 0; m_stop = 0;
            end
        end
        e_terr = tmo_now || (e_terr && !clr_err);
    endtask

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [NUM_CH-1:0]    el0, el1;
        logic [NUM_CH*12-1:0] ev0, ev1;
        @(negedge clk);
        if (chk_on) begin
            for (int c = 0; c < NUM_CH; c++) begin
                el0[c] = m_led[0][c];
                el1[c] = m_led[1][c];
                ev0[12*c +: 12] = 12'(mval(0, c));
                ev1[12*c +: 12] = 12'(mval(1, c));
            end
            check("den_u0",   64'(drp0.den),   64'(e_den));
            check("den_u1",   64'(drp1.den),   64'(e_den));
            check("dwe_u0",   64'(drp0.dwe),   64'(0));
            check("daddr_u0", 64'(drp0.daddr), 64'(e_daddr));
            check("daddr_u1", 64'(drp1.daddr), 64'(e_daddr));
            check("sv_u0",    64'(sv0),        64'(e_sv));
            check("sv_u1",    64'(sv1),        64'(e_sv));
            check("sch_u0",   64'(sch0),       64'(e_sch));
            check("terr_u0",  64'(terr0),      64'(e_terr));
            check("terr_u1",  64'(terr1),      64'(e_terr));
            check("led_u0",   64'(led0),       64'(el0));
            check("led_u1",   64'(led1),       64'(el1));
            check("value_u0", 64'(val0),       64'(ev0));
            check("value_u1", 64'(val1),       64'(ev1));
            if (drp0.den === 1'b1) begin den_cnt++; addr_log.push_back(drp0.daddr); end
            if (sv0 === 1'b1)      begin sv_cnt++;  sch_log.push_back(sch0);       end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input bit give, input logic [15:0] data, input int gap,
                           output logic [6:0] got);
        int t;
        eoc = 1'b1; tick(1); eoc = 1'b0;
        t = 0;
        while (drp0.den !== 1'b1 && t < 8) begin tick(1); t++; end
        check("den_seen", 64'(drp0.den), 64'(1));
        got = drp0.daddr;
        if (give) begin
            tick(3); drdy = 1'b1; do_in = data; tick(1); drdy = 1'b0;
        end
        tick(gap);
    endtask

    task automatic pulse_reset();
        tick(1); #2 resetn = 1'b0; tick(2); #2 resetn = 1'b1; tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [6:0] a;
        int         hi, base;
        logic [6:0] exp_addr[5] = '{7'h1E, 7'h17, 7'h1F, 7'h16, 7'h1E};
        logic [3:0] exp_sch[5]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        logic [11:0] exp_ema[3] = '{12'h3FF, 12'h6FF, 12'h93F};

        resetn = 1'b0; en = 1'b0; eoc = 1'b0; drdy = 1'b0; clr_err = 1'b0; do_in = '0;
        tick(1); chk_on = 1'b1;
        check("rst_den",   64'(drp0.den),   64'(0));
        check("rst_daddr", 64'(drp0.daddr), 64'(7'h1E));
        check("rst_led",   64'(led0),       64'(0));
        check("rst_value", 64'(val1),       64'(0));
        tick(2); #2 resetn = 1'b1;

        // zero values: LEDs never light, eoc ignored with en=0
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1); if (led0 != 0) hi++;
            if (i == 50) eoc = 1'b1; else eoc = 1'b0;
        end
        check("led_zero_duty", 64'(hi), 64'(0));
        check("idle_no_den", 64'(den_cnt), 64'(0));

        // round robin at default data
        en = 1'b1; tick(2);
        for (int r = 0; r < 5; r++) begin
            do_read(1'b1, 16'hA5F0, 20, a);
            if (r == 0) begin
                check("value0_raw", 64'(val0[11:0]), 64'(12'hA5F));
                check("value0_ema", 64'(val1[11:0]), 64'(12'h297));
            end
        end
        check("addr_log_n", 64'(addr_log.size()), 64'(5));
        check("sch_log_n",  64'(sch_log.size()),  64'(5));
        for (int r = 0; r < 5; r++) begin
            if (r < addr_log.size()) check("addr_seq", 64'(addr_log[r]), 64'(exp_addr[r]));
            if (r < sch_log.size())  check("sch_seq",  64'(sch_log[r]),  64'(exp_sch[r]));
        end

        // PWM duty 0x40 on channel 2
        do_read(1'b1, 16'hA5F0, 20, a);
        do_read(1'b1, 16'h4000, 20, a);
        check("value2", 64'(val0[35:24]), 64'(12'h400));
        tick(300);
        hi = 0;
        for (int i = 0; i < 256; i++) begin tick(1); if (led0[2]) hi++; end
        check("led2_high_cnt", 64'(hi), 64'(64));
        do_read(1'b1, 16'hA5F0, 20, a);

        // EMA from zero with raw FFF
        pulse_reset();
        for (int r = 0; r < 9; r++) begin
            do_read(1'b1, 16'hFFF0, 20, a);
            if (r % 4 == 0) begin
                check("ema_value0", 64'(val1[11:0]), 64'(exp_ema[r/4]));
                check("raw_value0", 64'(val0[11:0]), 64'(12'hFFF));
            end
        end

        // timeout on channel 1
        do_read(1'b0, 16'h0000, 270, a);
        check("timeout_err_set", 64'(terr0), 64'(1));
        check("value1_kept",     64'(val0[23:12]), 64'(12'hFFF));
        do_read(1'b1, 16'h8000, 20, a);
        check("addr_after_tmo",  64'(a), 64'(7'h1F));
        check("timeout_err_sticky", 64'(terr0), 64'(1));
        clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
        check("timeout_err_clr", 64'(terr0), 64'(0));

        // en dropped one cycle after den: read completes, then idle
        base = sv_cnt;
        eoc = 1'b1; tick(1); eoc = 1'b0;
        check("den_ch3", 64'(drp0.den), 64'(1));
        tick(1); en = 1'b0;
        tick(2); drdy = 1'b1; do_in = 16'h1230; tick(1); drdy = 1'b0;
        tick(1);
        check("sv_after_en_drop", 64'(sv_cnt), 64'(base + 1));
        check("value3", 64'(val0[47:36]), 64'(12'h123));
        base = den_cnt;
        for (int i = 0; i < 3; i++) begin eoc = 1'b1; tick(1); eoc = 1'b0; tick(5); end
        check("no_den_idle", 64'(den_cnt), 64'(base));

        // reset while a read is in flight
        en = 1'b1; tick(2);
        do_read(1'b1, 16'hA5F0, 20, a);
        eoc = 1'b1; tick(1); eoc = 1'b0; tick(1);
        #2 resetn = 1'b0; #1;
        check("rst_mid_den", 64'(drp0.den), 64'(0));
        check("rst_mid_led", 64'({led1, led0}), 64'(0));
        tick(2); #2 resetn = 1'b1;
        base = sv_cnt;
        tick(1); drdy = 1'b1; do_in = 16'hFFF0; tick(1); drdy = 1'b0; tick(2);
        check("late_drdy_ignored", 64'(sv_cnt), 64'(base));
        do_read(1'b1, 16'hA5F0, 10, a);
        check("addr_after_reset", 64'(a), 64'(7'h1E));

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xadc_multi_pwm.md
Name: xadc_multi_pwm

Overview:
- Parametrised XADC DRP read sequencer plus per-channel PWM brightness driver.
- Round-robins a configurable list of XADC channel addresses and reads one channel per end-of-conversion.
- Captures 12-bit results, optionally smooths them with an exponential moving average, and drives one PWM LED per channel.
- Sits between an external XADC wizard instance (DRP side) and the board LEDs. Adds a DRP timeout, run enable and sample strobes.

Parameters:
- NUM_CH, 4, number of channels/LEDs (1..16).
- CH_ADDRS, {7'h16,7'h1F,7'h17,7'h1E}, packed DRP addresses; channel i = CH_ADDRS[7*i+6:7*i].
- PWM_BITS, 8, PWM resolution (1..12).
- AVG_SHIFT, 0, EMA shift; 0 = no filtering (0..4).
- TIMEOUT, 255, max cycles to wait for drdy after den (>=4).

Ports:
- clk  in  1  system clock; XADC dclk is the same clock.
- resetn  in  1  asynchronous active-low reset.
- en  in  1  run enable for the sequencer.
- eoc  in  1  XADC end-of-conversion pulse.
- drdy  in  1  XADC DRP data-ready pulse.
- do_in  in  16  XADC DRP read data.
- den  out  1  DRP enable, single-cycle pulse.
- dwe  out  1  DRP write enable, constant 0.
- daddr  out  7  DRP address.
- clr_err  in  1  clears timeout_err.
- led  out  NUM_CH  PWM outputs, bit i = channel i.
- value  out  NUM_CH*12  filtered 12-bit result per channel; channel i at [12*i+11:12*i].
- sample_valid  out  1  one-cycle strobe when a channel's value updates.
- sample_ch  out  4  index of the channel just updated.
- timeout_err  out  1  sticky flag: a DRP read timed out.

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, den=0, daddr=CH_ADDRS[0], led=0, all value/accumulators=0, sample_valid=0, sample_ch=0, timeout_err=0, PWM counter=0, all duties=0.
- IDLE:
  - en=1 -> WAIT_EOC.
  - eoc is ignored while in IDLE.
- WAIT_EOC:
  - If en=0 -> IDLE.
  - On eoc=1: drive den=1 for exactly one cycle with daddr=CH_ADDRS[idx], clear timer, go to WAIT_DRDY.
- WAIT_DRDY:
  - daddr is held stable from the den cycle until exit.
  - eoc is ignored.
  - On drdy=1: raw=do_in[15:4], update channel idx, pulse sample_valid with sample_ch=idx on the following cycle, advance idx (NUM_CH-1 wraps to 0), go to WAIT_EOC.
  - If en was deasserted during the read, finish the read, then go to IDLE.
- Timeout:
  - The timer counts each cycle in WAIT_DRDY; when it reaches TIMEOUT without drdy, set timeout_err=1 and advance idx.
  - No value update and no sample_valid; return to WAIT_EOC.
  - If drdy and the timeout occur in the same cycle, drdy wins.
- timeout_err:
  - Stays set until clr_err=1.
  - If set and clear occur in the same cycle, set wins.
- Filter:
  - AVG_SHIFT=0: value=raw.
  - Otherwise: (12+AVG_SHIFT)-bit accumulator acc <= acc - (acc>>AVG_SHIFT) + raw; value=acc>>AVG_SHIFT. No overflow is possible at these widths.
- DRP read latency: den -> value visible 1 cycle after drdy.
- PWM:
  - Free-running PWM_BITS counter, wraps at 2^PWM_BITS-1 -> 0.
  - When count==2^PWM_BITS-1, latch duty[i]=value_i[11 -: PWM_BITS]; the new duty takes effect from count 0.
  - led[i] = (count < duty[i]), registered.
  - duty 0 = fully off; max duty = (2^PWM_BITS-1)/2^PWM_BITS on.
  - PWM runs independently of en; with en=0 the LEDs hold their last duties.

Test Plan:
- Defaults: en=1, eoc every 100 cycles, drdy 3 cycles after den, do_in=16'hA5F0 -> den pulses carry daddr 1E,17,1F,16,1E...; value0=12'hA5F; sample_ch sequence 0,1,2,3,0.
- PWM: value2=12'h400 -> duty2=8'h40; led[2] high exactly 64 of every 256 cycles. value=0 -> led never high.
- Timeout: drdy withheld on channel 1 -> after 255 cycles timeout_err=1, value1 unchanged, next den uses 7'h1F. clr_err pulse -> flag=0.
- AVG_SHIFT=2, repeated raw=12'hFFF from 0 -> value sequence 3FF, 6FF, 93F...; monotonically approaches FFF.
- en dropped one cycle after den -> drdy still captured and sample_valid pulses, then IDLE; further eoc produce no den.
- resetn asserted in WAIT_DRDY -> den=0, idx=0, leds 0 immediately; a late drdy after release is ignored until a new den.
